// File: rtl/muldiv_ctrl.sv
// HI/LO multiply-divide sequencer: fixed-latency multiply, restoring divide with sign fixup,
// architectural HI/LO ownership and stall generation for accesses during an operation.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned W       = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         md_start,
  input  logic [1:0]   md_op,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] hilo_wdata,
  input  logic         hilo_rd,
  input  logic         md_flush,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         busy,
  output logic         stall
);

  localparam int unsigned CntMax = (W > MUL_LAT) ? W : MUL_LAT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StSign} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    quo_q, quo_d;
  logic [W-1:0]    dvs_q, dvs_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;

  logic           op_signed;
  logic [W-1:0]   rs_mag, rt_mag;
  logic [2*W-1:0] rs_ext, rt_ext;
  logic [W:0]     rem_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    op_signed = md_op[0];
    rs_mag    = (op_signed && rs_val[W-1]) ? -rs_val : rs_val;
    rt_mag    = (op_signed && rt_val[W-1]) ? -rt_val : rt_val;
    rs_ext    = op_signed ? {{W{rs_val[W-1]}}, rs_val} : {{W{1'b0}}, rs_val};
    rt_ext    = op_signed ? {{W{rt_val[W-1]}}, rt_val} : {{W{1'b0}}, rt_val};
    // Partial remainder after the left shift; one extra bit so large unsigned divisors compare right.
    rem_sh    = {rem_q, quo_q[W-1]};

    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      StIdle: begin
        if (!md_flush) begin
          if (md_start) begin
            if (!md_op[1]) begin
              state_d = StMul;
              prod_d  = rs_ext * rt_ext;
              cnt_d   = CntW'(MUL_LAT - 1);
            end else if (rt_val != '0) begin
              state_d = StDiv;
              dvs_d   = rt_mag;
              quo_d   = rs_mag;
              rem_d   = '0;
              qneg_d  = op_signed & (rs_val[W-1] ^ rt_val[W-1]);
              rneg_d  = op_signed & rs_val[W-1];
              cnt_d   = CntW'(W - 1);
            end else begin
              // Divide by zero: SIGN passes these through untouched.
              state_d = StSign;
              rem_d   = rs_val;
              quo_d   = '1;
              qneg_d  = 1'b0;
              rneg_d  = 1'b0;
            end
          end else begin
            if (hi_we) hi_d = hilo_wdata;
            if (lo_we) lo_d = hilo_wdata;
          end
        end
      end
      StMul: begin
        if (md_flush) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          hi_d    = prod_q[2*W-1:W];
          lo_d    = prod_q[W-1:0];
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDiv: begin
        if (md_flush) begin
          state_d = StIdle;
        end else begin
          if (rem_sh >= {1'b0, dvs_q}) begin
            rem_d = W'(rem_sh - {1'b0, dvs_q});
            quo_d = {quo_q[W-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b0};
          end
          if (cnt_q == '0) state_d = StSign;
          else             cnt_d   = cnt_q - CntW'(1);
        end
      end
      StSign: begin
        state_d = StIdle;
        if (!md_flush) begin
          lo_d = qneg_q ? -quo_q : quo_q;
          hi_d = rneg_q ? -rem_q : rem_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy  = (state_q != StIdle);
    stall = busy & (md_start | hi_we | lo_we | hilo_rd) & ~md_flush;
    hi    = hi_q;
    lo    = lo_q;
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: multiply/divide results, busy lengths, stall, flush and reset.
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst_n;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hilo_wdata;
  logic        hilo_rd;
  logic        md_flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  int n_vec;
  int n_err;
  int nb;

  localparam logic [1:0] OpMultu = 2'b00;
  localparam logic [1:0] OpMult  = 2'b01;
  localparam logic [1:0] OpDivu  = 2'b10;
  localparam logic [1:0] OpDiv   = 2'b11;

  muldiv_ctrl #(
    .MUL_LAT(4),
    .W      (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .md_start  (md_start),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .hilo_wdata(hilo_wdata),
    .hilo_rd   (hilo_rd),
    .md_flush  (md_flush),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall     (stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and count the cycles busy stays high (bounded).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    md_start = 1'b1;
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    tick();
    md_start = 1'b0;
    cycles   = 0;
    while (busy && cycles < 200) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    md_start   = 1'b0;
    md_op      = 2'b00;
    rs_val     = '0;
    rt_val     = '0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hilo_wdata = '0;
    hilo_rd    = 1'b1;
    md_flush   = 1'b0;

    #3;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    #10;
    rst_n   = 1'b1;
    hilo_rd = 1'b0;
    tick();

    run_op(OpMult, 32'hFFFF_FFFE, 32'd3, nb);
    chk("mult_busy", nb, 32'd4);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // Back-to-back: issued in the cycle busy fell.
    run_op(OpMultu, 32'hFFFF_FFFE, 32'd3, nb);
    chk("multu_busy", nb, 32'd4);
    chk("multu_hi", hi, 32'h0000_0002);
    chk("multu_lo", lo, 32'hFFFF_FFFA);

    run_op(OpDiv, 32'hFFFF_FFF9, 32'd2, nb);
    chk("div_busy", nb, 32'd33);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    run_op(OpDivu, 32'd7, 32'd2, nb);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    run_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    run_op(OpDivu, 32'hFFFF_FFFF, 32'h8000_0001, nb);
    chk("bigdvs_lo", lo, 32'd1);
    chk("bigdvs_hi", hi, 32'h7FFF_FFFE);

    run_op(OpDivu, 32'h1234, 32'd0, nb);
    chk("dz_busy", nb, 32'd1);
    chk("dz_hi", hi, 32'h1234);
    chk("dz_lo", lo, 32'hFFFF_FFFF);

    // Start wins over a simultaneous MTHI.
    hi_we      = 1'b1;
    hilo_wdata = 32'hDEAD;
    run_op(OpMultu, 32'd2, 32'd3, nb);
    hi_we = 1'b0;
    chk("startwin_hi", hi, 32'h0);
    chk("startwin_lo", lo, 32'd6);

    // MFHI held through a multiply.
    md_start = 1'b1;
    md_op    = OpMultu;
    rs_val   = 32'd5;
    rt_val   = 32'd5;
    tick();
    md_start = 1'b0;
    hilo_rd  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rd_stall", {31'b0, stall}, 32'h1);
      tick();
    end
    chk("rd_busy_fell", {31'b0, busy}, 32'h0);
    chk("rd_stall_fell", {31'b0, stall}, 32'h0);
    chk("rd_lo", lo, 32'd25);
    hilo_rd = 1'b0;

    hi_we      = 1'b1;
    hilo_wdata = 32'hAAAA;
    tick();
    hi_we = 1'b0;
    chk("mthi", hi, 32'hAAAA);

    md_start = 1'b1;
    md_op    = OpDivu;
    rs_val   = 32'd100;
    rt_val   = 32'd3;
    tick();
    md_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    md_flush = 1'b1;
    hilo_rd  = 1'b1;
    #1;
    chk("flush_nostall", {31'b0, stall}, 32'h0);
    tick();
    md_flush = 1'b0;
    hilo_rd  = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'h0);
    chk("flush_hi", hi, 32'hAAAA);
    chk("flush_lo", lo, 32'd25);

    // Flush in IDLE suppresses the write.
    hi_we      = 1'b1;
    md_flush   = 1'b1;
    hilo_wdata = 32'h5;
    tick();
    hi_we    = 1'b0;
    md_flush = 1'b0;
    chk("idleflush_hi", hi, 32'hAAAA);

    md_start = 1'b1;
    md_op    = OpDivu;
    rs_val   = 32'd100;
    rt_val   = 32'd3;
    tick();
    md_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'h0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op(OpMult, 32'd6, 32'd7, nb);
    chk("post_rst_lo", lo, 32'd42);
    chk("post_rst_hi", hi, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
